// File: rtl/task_6_stream_arbiter.sv
// Packet-granular round-robin arbiter that shares one byte-stream input stage among NUM_SRC sources.
// A grant is held from the first beat until last (or the length guard), followed by a one-cycle gap.
module task_6_stream_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int MAX_PKT_LEN = 256,
    localparam int IDW = $clog2(NUM_SRC),
    localparam int CW  = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_SRC-1:0]   i_src_valid,
    input  logic [8*NUM_SRC-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]   i_src_last,
    output logic [NUM_SRC-1:0]   o_src_ready,
    output logic                 o_tdata_valid,
    output logic [7:0]           o_tdata,
    output logic                 o_tdata_last,
    input  logic                 i_tready,
    output logic                 o_grant_valid,
    output logic [IDW-1:0]       o_grant_id,
    output logic                 o_pkt_done,
    output logic                 o_overflow,
    output logic [1:0]           o_state
);

    // Handshake: a beat moves when o_tdata_valid && i_tready on a rising edge; the granted
    // source sees o_src_ready = i_tready, so its valid/ready pair is the downstream pair.
    typedef enum logic [1:0] {
        s_IDLE = 2'd0,
        s_XFER = 2'd1,
        s_GAP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;

    logic [7:0]     data_arr [NUM_SRC];
    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           sel_valid, sel_last, at_limit, beat;
    logic [7:0]     sel_data;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign data_arr[k] = i_src_data[8*k +: 8];
    end

    // Scan starts one past the last served source, so it gets lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = IDW'((int'(rr_q) + i) % NUM_SRC);
            if (!found && i_src_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign sel_valid = i_src_valid[grant_q];
    assign sel_last  = i_src_last[grant_q];
    assign sel_data  = data_arr[grant_q];
    assign at_limit  = (cnt_q == CW'(MAX_PKT_LEN - 1));
    assign beat      = (state_q == s_XFER) && sel_valid && i_tready;

    always_comb begin
        o_src_ready   = '0;
        o_tdata_valid = 1'b0;
        o_tdata       = '0;
        o_tdata_last  = 1'b0;
        if (state_q == s_XFER) begin
            o_src_ready[grant_q] = i_tready;
            o_tdata_valid        = sel_valid;
            o_tdata              = sel_data;
            o_tdata_last         = sel_valid && (sel_last || at_limit);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            s_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = s_XFER;
                end
            end
            s_XFER: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    // A guard-terminated packet still ends cleanly with a last beat.
                    if (sel_last || at_limit) begin
                        state_d = s_GAP;
                        rr_d    = grant_q;
                        done_d  = 1'b1;
                        ovf_d   = !sel_last;
                    end
                end
            end
            s_GAP:   state_d = s_IDLE;
            default: state_d = s_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= s_IDLE;
            grant_q <= '0;
            rr_q    <= IDW'(NUM_SRC - 1);
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_grant_valid = (state_q == s_XFER);
    assign o_grant_id    = grant_q;
    assign o_pkt_done    = done_q;
    assign o_overflow    = ovf_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_task_6_stream_arbiter.sv
// Directed bench for task_6_stream_arbiter: per-source beat queues feed the DUT, a monitor
// pops expected {grant_id, byte, last} beats and packet-done events from scoreboard queues.
module tb_task_6_stream_arbiter;

    localparam int NUM_SRC = 4;
    localparam int MAXLEN  = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_src_valid = '0;
    logic [31:0] i_src_data  = '0;
    logic [3:0]  i_src_last  = '0;
    logic        i_tready    = 1'b1;
    logic [3:0]  o_src_ready;
    logic        o_tdata_valid;
    logic [7:0]  o_tdata;
    logic        o_tdata_last;
    logic        o_grant_valid;
    logic [1:0]  o_grant_id;
    logic        o_pkt_done;
    logic        o_overflow;
    logic [1:0]  dbg_state;

    task_6_stream_arbiter #(.NUM_SRC(NUM_SRC), .MAX_PKT_LEN(MAXLEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_src_valid(i_src_valid), .i_src_data(i_src_data), .i_src_last(i_src_last),
        .o_src_ready(o_src_ready),
        .o_tdata_valid(o_tdata_valid), .o_tdata(o_tdata), .o_tdata_last(o_tdata_last),
        .i_tready(i_tready),
        .o_grant_valid(o_grant_valid), .o_grant_id(o_grant_id),
        .o_pkt_done(o_pkt_done), .o_overflow(o_overflow), .o_state(dbg_state)
    );

    always #5 i_clk = ~i_clk;

    int compared   = 0;
    int mismatched = 0;

    logic [10:0] exp_q[$];
    logic        done_q[$];

    logic [8:0]  src_mem [NUM_SRC][32];
    int          src_wr [NUM_SRC];
    int          src_rd [NUM_SRC];
    logic [3:0]  fire = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic load(input int k, input logic [7:0] d, input logic l);
        src_mem[k][src_wr[k]] = {l, d};
        src_wr[k]++;
    endtask

    task automatic expb(input logic [1:0] id, input logic [7:0] d, input logic l);
        exp_q.push_back({id, d, l});
    endtask

    task automatic wait_grant(input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            if (o_grant_valid === 1'b1) break;
            tick();
        end
        if (c == budget) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && done_q.size() == 0 && o_grant_valid === 1'b0) break;
            tick();
        end
        if (c == budget) check("drain_timeout", 32'd0, 32'd1);
        tick();
    endtask

    // Source driver: a beat accepted at an edge advances that source's queue.
    always @(negedge i_clk) fire = i_rst ? 4'b0 : (i_src_valid & o_src_ready);

    always @(posedge i_clk) begin
        #1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (fire[k]) src_rd[k]++;
            if (src_rd[k] < src_wr[k]) begin
                i_src_valid[k]       = 1'b1;
                i_src_data[8*k +: 8] = src_mem[k][src_rd[k]][7:0];
                i_src_last[k]        = src_mem[k][src_rd[k]][8];
            end else begin
                i_src_valid[k]       = 1'b0;
                i_src_data[8*k +: 8] = 8'h00;
                i_src_last[k]        = 1'b0;
            end
        end
    end

    // Monitor
    logic        prev_last_beat = 1'b0;
    logic        prev_gv = 1'b0;
    logic [1:0]  prev_id = '0;
    logic [10:0] e;
    logic        e_ovf;

    always @(negedge i_clk) begin
        if (o_pkt_done === 1'b1) begin
            check("done_after_last", {31'd0, prev_last_beat}, 32'd1);
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e_ovf = done_q.pop_front();
                check("overflow_flag", {31'd0, o_overflow}, {31'd0, e_ovf});
            end
        end else if (o_overflow === 1'b1) begin
            check("overflow_without_done", 32'd1, 32'd0);
        end
        if (i_rst === 1'b0 && o_grant_valid === 1'b1) begin
            check("ready_mirror", {28'd0, o_src_ready}, {28'd0, 4'(i_tready) << o_grant_id});
            if (prev_gv) check("grant_hold", {30'd0, o_grant_id}, {30'd0, prev_id});
        end
        prev_last_beat = 1'b0;
        if (o_tdata_valid === 1'b1 && i_tready === 1'b1) begin
            prev_last_beat = o_tdata_last;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {21'd0, o_grant_id, o_tdata, o_tdata_last}, 32'h7ff);
            end else begin
                e = exp_q.pop_front();
                check("beat", {21'd0, o_grant_id, o_tdata, o_tdata_last}, {21'd0, e});
            end
        end
        prev_gv = (o_grant_valid === 1'b1);
        prev_id = o_grant_id;
    end

    initial begin
        #300000;
        check("watchdog", 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NUM_SRC; k++) begin
            src_wr[k] = 0;
            src_rd[k] = 0;
        end

        // T1 + T3: every source has a 2-beat packet, src0 a second one; order 0,1,2,3,0
        for (int k = 0; k < NUM_SRC; k++) begin
            load(k, 8'(16*k), 1'b0);
            load(k, 8'(16*k + 1), 1'b1);
        end
        load(0, 8'h02, 1'b0);
        load(0, 8'h03, 1'b1);
        for (int k = 0; k < NUM_SRC; k++) begin
            expb(2'(k), 8'(16*k), 1'b0);
            expb(2'(k), 8'(16*k + 1), 1'b1);
            done_q.push_back(1'b0);
        end
        expb(2'd0, 8'h02, 1'b0);
        expb(2'd0, 8'h03, 1'b1);
        done_q.push_back(1'b0);
        i_rst    = 1'b1;
        i_tready = 1'b1;
        tick();
        check("reset_outputs_1", {13'd0, o_src_ready, o_tdata_valid, o_tdata, o_tdata_last,
              o_grant_valid, o_grant_id, o_pkt_done, o_overflow}, 32'd0);
        tick();
        check("reset_outputs_2", {13'd0, o_src_ready, o_tdata_valid, o_tdata, o_tdata_last,
              o_grant_valid, o_grant_id, o_pkt_done, o_overflow}, 32'd0);
        i_rst = 1'b0;
        tick();
        check("first_grant", {30'd0, o_grant_valid, o_grant_id[0]}, 32'd2);
        check("first_grant_id", {30'd0, o_grant_id}, 32'd0);
        wait_drain(200);

        // T2: single 3-byte packet from src2
        load(2, 8'hA1, 1'b0);
        load(2, 8'hA2, 1'b0);
        load(2, 8'hA3, 1'b1);
        expb(2'd2, 8'hA1, 1'b0);
        expb(2'd2, 8'hA2, 1'b0);
        expb(2'd2, 8'hA3, 1'b1);
        done_q.push_back(1'b0);
        wait_grant(50);
        check("t2_grant_id", {30'd0, o_grant_id}, 32'd2);
        wait_drain(100);

        // T4: backpressure 1,0,0,1; exactly MAXLEN beats with real last -> no overflow
        i_tready = 1'b0;
        load(3, 8'hB1, 1'b0);
        load(3, 8'hB2, 1'b0);
        load(3, 8'hB3, 1'b0);
        load(3, 8'hB4, 1'b1);
        expb(2'd3, 8'hB1, 1'b0);
        expb(2'd3, 8'hB2, 1'b0);
        expb(2'd3, 8'hB3, 1'b0);
        expb(2'd3, 8'hB4, 1'b1);
        done_q.push_back(1'b0);
        wait_grant(50);
        check("t4_grant_id", {30'd0, o_grant_id}, 32'd3);
        i_tready = 1'b1;
        tick();
        i_tready = 1'b0;
        tick();
        tick();
        check("t4_stall_ready", {28'd0, o_src_ready}, 32'd0);
        i_tready = 1'b1;
        wait_drain(100);

        // T5: length guard on beat 4, remaining beats form a second packet
        for (int b = 1; b <= 6; b++) load(1, 8'(8'hC0 + b), (b == 6));
        expb(2'd1, 8'hC1, 1'b0);
        expb(2'd1, 8'hC2, 1'b0);
        expb(2'd1, 8'hC3, 1'b0);
        expb(2'd1, 8'hC4, 1'b1);
        done_q.push_back(1'b1);
        expb(2'd1, 8'hC5, 1'b0);
        expb(2'd1, 8'hC6, 1'b1);
        done_q.push_back(1'b0);
        wait_drain(100);

        // T6: reset after beat 2 of 5, packet dropped, fresh arbitration from src0
        i_tready = 1'b0;
        for (int b = 1; b <= 5; b++) load(1, 8'(8'hD0 + b), (b == 5));
        expb(2'd1, 8'hD1, 1'b0);
        expb(2'd1, 8'hD2, 1'b0);
        wait_grant(50);
        check("t6_grant_id", {30'd0, o_grant_id}, 32'd1);
        i_tready = 1'b1;
        tick();
        tick();
        i_tready = 1'b0;
        i_rst    = 1'b1;
        tick();
        check("t6_reset_outputs", {13'd0, o_src_ready, o_tdata_valid, o_tdata, o_tdata_last,
              o_grant_valid, o_grant_id, o_pkt_done, o_overflow}, 32'd0);
        check("t6_beats_before_reset", exp_q.size(), 32'd0);
        src_rd[1] = src_wr[1];
        load(0, 8'hF1, 1'b1);
        load(1, 8'hE1, 1'b1);
        expb(2'd0, 8'hF1, 1'b1);
        expb(2'd1, 8'hE1, 1'b1);
        done_q.push_back(1'b0);
        done_q.push_back(1'b0);
        tick();
        check("t6_no_done", {31'd0, o_pkt_done}, 32'd0);
        i_tready = 1'b1;
        i_rst    = 1'b0;
        tick();
        check("t6_regrant", {30'd0, o_grant_valid, 1'b0}, 32'd2);
        check("t6_regrant_id", {30'd0, o_grant_id}, 32'd0);
        wait_drain(100);

        check("exp_q_empty", exp_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
